// File: rtl/icache_mp_if.sv
// rtl/icache_mp_if.sv - fetch and program-memory bus bundle for icache_mp
//
// Ports carried (cache view, modport slave):
//   fetch_valid        in  NUM_PORTS            per-port request
//   fetch_pc           in  NUM_PORTS*ADDR_BITS  per-port address, port p at [p*ADDR_BITS +: ADDR_BITS]
//   fetch_ready        out NUM_PORTS            one-cycle response pulse per port
//   fetch_instruction  out NUM_PORTS*DATA_BITS  per-port instruction, packed like fetch_pc
//   mem_read_valid     out 1                    miss request to program memory
//   mem_read_address   out ADDR_BITS            miss address
//   mem_read_ready     in  1                    memory data valid
//   mem_read_data      in  DATA_BITS            memory data
// modport master is the environment side (fetchers plus program memory).
interface icache_mp_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic [NUM_PORTS-1:0]           fetch_valid;
    logic [NUM_PORTS*ADDR_BITS-1:0] fetch_pc;
    logic [NUM_PORTS-1:0]           fetch_ready;
    logic [NUM_PORTS*DATA_BITS-1:0] fetch_instruction;
    logic                           mem_read_valid;
    logic [ADDR_BITS-1:0]           mem_read_address;
    logic                           mem_read_ready;
    logic [DATA_BITS-1:0]           mem_read_data;

    modport master (
        output fetch_valid, fetch_pc, mem_read_ready, mem_read_data,
        input  fetch_ready, fetch_instruction, mem_read_valid, mem_read_address
    );

    modport slave (
        input  fetch_valid, fetch_pc, mem_read_ready, mem_read_data,
        output fetch_ready, fetch_instruction, mem_read_valid, mem_read_address
    );
endinterface

// File: rtl/icache_mp.sv
// rtl/icache_mp.sv - multi-port direct-mapped instruction cache with round-robin arbitration
//
// Ports:
//   clk         in  1         clock
//   reset       in  1         synchronous, active-high
//   flush       in  1         invalidate every line
//   bus         slave of icache_mp_if (fetch request/response ports, program memory read port)
//   hit_count   out CNT_BITS  saturating hit counter
//   miss_count  out CNT_BITS  saturating miss counter
module icache_mp #(
    parameter int NUM_PORTS   = 2,
    parameter int CACHE_LINES = 16,
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 16,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    icache_mp_if.slave          bus,
    output logic [CNT_BITS-1:0] hit_count,
    output logic [CNT_BITS-1:0] miss_count
);
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;
    localparam int PTR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FETCH  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CACHE_LINES-1:0] line_valid;
    logic [TAG_BITS-1:0]    line_tag  [CACHE_LINES];
    logic [DATA_BITS-1:0]   line_data [CACHE_LINES];

    logic [PTR_BITS-1:0]  rr;
    logic [PTR_BITS-1:0]  grant;
    logic [PTR_BITS-1:0]  grant_sel;
    logic [PTR_BITS-1:0]  cand;
    logic                 grant_found;
    logic [ADDR_BITS-1:0] req_pc;
    logic                 fill_cancel;

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic                 lookup_hit;
    logic [NUM_PORTS-1:0] eligible;

    logic do_grant, do_hit, do_miss, do_fill;

    assign req_idx    = req_pc[IDX_BITS-1:0];
    assign req_tag    = req_pc[ADDR_BITS-1:IDX_BITS];
    assign lookup_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    // A port whose response is on the bus this cycle is not re-arbitrated
    // until the following cycle.
    assign eligible = bus.fetch_valid & ~bus.fetch_ready;

    // Round-robin: first eligible port at or after rr, wrapping upward.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = rr;
        cand        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PTR_BITS'((int'(rr) + k) % NUM_PORTS);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_fill    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    do_grant   = 1'b1;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    do_hit     = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    do_miss    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_read_ready) begin
                    do_fill    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line payload needs no reset; the valid bits alone decide a hit.
    always_ff @(posedge clk) begin
        if (!reset && do_fill) begin
            line_tag[req_idx]  <= req_tag;
            line_data[req_idx] <= bus.mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_valid            <= '0;
            rr                    <= '0;
            grant                 <= '0;
            req_pc                <= '0;
            fill_cancel           <= 1'b0;
            bus.fetch_ready       <= '0;
            bus.fetch_instruction <= '0;
            bus.mem_read_valid    <= 1'b0;
            bus.mem_read_address  <= '0;
            hit_count             <= '0;
            miss_count            <= '0;
        end else begin
            bus.fetch_ready <= '0;

            if (do_grant) begin
                grant       <= grant_sel;
                req_pc      <= bus.fetch_pc[grant_sel*ADDR_BITS +: ADDR_BITS];
                rr          <= (int'(grant_sel) == NUM_PORTS - 1) ? '0 : grant_sel + 1'b1;
                fill_cancel <= 1'b0;
            end

            if (do_hit) begin
                bus.fetch_ready[grant]                           <= 1'b1;
                bus.fetch_instruction[grant*DATA_BITS +: DATA_BITS] <= line_data[req_idx];
                if (hit_count != '1) begin
                    hit_count <= hit_count + 1'b1;
                end
            end

            if (do_miss) begin
                bus.mem_read_valid   <= 1'b1;
                bus.mem_read_address <= req_pc;
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end

            // A flush seen while the miss is outstanding poisons the fill:
            // the requester still gets its data but the line stays invalid.
            if (state == S_FETCH && flush) begin
                fill_cancel <= 1'b1;
            end

            if (do_fill) begin
                bus.fetch_ready[grant]                              <= 1'b1;
                bus.fetch_instruction[grant*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
                bus.mem_read_valid                                  <= 1'b0;
            end

            if (flush) begin
                line_valid <= '0;
            end else if (do_fill && !fill_cancel) begin
                line_valid[req_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_mp.sv
// tb/tb_icache_mp.sv - self-checking bench for icache_mp
module tb_icache_mp;
    localparam int NP   = 2;
    localparam int CL   = 16;
    localparam int AB   = 8;
    localparam int DB   = 16;
    localparam int CB   = 3;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [CB-1:0] hit_count;
    logic [CB-1:0] miss_count;

    icache_mp_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();

    icache_mp #(
        .NUM_PORTS(NP), .CACHE_LINES(CL), .ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: which pc each line currently holds; memory is a fixed function of pc.
    bit   m_valid [CL];
    int   m_tag   [CL];
    int   m_hits;
    int   m_misses;

    typedef struct {
        int           port;
        logic [AB-1:0] pc;
        bit           flush_before;
        int           delay;
        bit           flush_in_fetch;
        bit           exp_hit;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DB-1:0] mem_data(input logic [AB-1:0] pc);
        if (pc == 8'h23) return 16'hBEEF;
        return {pc ^ 8'hA5, pc};
    endfunction

    function automatic logic [DB-1:0] instr_of(input int p);
        return bus.fetch_instruction[p*DB +: DB];
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic bit model_hit(input logic [AB-1:0] pc);
        return m_valid[int'(pc) % CL] && (m_tag[int'(pc) % CL] == int'(pc) / CL);
    endfunction

    task automatic model_flush();
        for (int i = 0; i < CL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check_counters();
        check("hit_count", 64'(hit_count), 64'(sat(m_hits)));
        check("miss_count", 64'(miss_count), 64'(sat(m_misses)));
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        flush              = 1'b0;
        bus.fetch_valid    = '0;
        bus.fetch_pc       = '0;
        bus.mem_read_ready = 1'b0;
        bus.mem_read_data  = '0;
        step();
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_flush();
    endtask

    // One isolated request; the port drops valid and scrambles its pc right
    // after being sampled, so completion must come from the latched request.
    task automatic do_req(input int port, input logic [AB-1:0] pc, input bit exp_hit,
                          input int delay, input bit flush_in_fetch);
        logic [DB-1:0] exp_d;
        exp_d = mem_data(pc);
        bus.fetch_valid[port]          = 1'b1;
        bus.fetch_pc[port*AB +: AB]    = pc;
        step();
        bus.fetch_valid[port]          = 1'b0;
        bus.fetch_pc[port*AB +: AB]    = ~pc;
        check("lookup_quiet", 64'({bus.fetch_ready, bus.mem_read_valid}), 64'd0);
        step();
        if (exp_hit) begin
            check("hit_ready", 64'(bus.fetch_ready), 64'(1 << port));
            check("hit_data", 64'(instr_of(port)), 64'(exp_d));
            check("hit_no_mem", 64'(bus.mem_read_valid), 64'd0);
            m_hits++;
        end else begin
            check("miss_ready", 64'(bus.fetch_ready), 64'd0);
            check("miss_mem_valid", 64'(bus.mem_read_valid), 64'd1);
            check("miss_addr", 64'(bus.mem_read_address), 64'(pc));
            m_misses++;
            for (int i = 0; i < delay; i++) begin
                if (flush_in_fetch && i == 0) flush = 1'b1;
                step();
                flush = 1'b0;
                check("mem_hold", 64'({bus.mem_read_valid, bus.mem_read_address}), 64'({1'b1, pc}));
                check("fetch_wait_ready", 64'(bus.fetch_ready), 64'd0);
            end
            if (flush_in_fetch && delay == 0) flush = 1'b1;
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = exp_d;
            step();
            bus.mem_read_ready = 1'b0;
            bus.mem_read_data  = DB'($urandom);
            flush              = 1'b0;
            check("fill_ready", 64'(bus.fetch_ready), 64'(1 << port));
            check("fill_data", 64'(instr_of(port)), 64'(exp_d));
            check("fill_mem_low", 64'(bus.mem_read_valid), 64'd0);
            if (flush_in_fetch) begin
                model_flush();
            end else begin
                m_valid[int'(pc) % CL] = 1'b1;
                m_tag[int'(pc) % CL]   = int'(pc) / CL;
            end
        end
        check_counters();
        step();
        check("ready_pulse", 64'(bus.fetch_ready), 64'd0);
    endtask

    initial begin
        logic [NP-1:0] exp_rdy;
        int            rp;
        logic [AB-1:0] rpc;

        //           port  pc     flb dly fif hit
        vecs[0]  = '{0, 8'h23, 1'b0, 3, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'h23, 1'b0, 0, 1'b0, 1'b1};
        vecs[2]  = '{1, 8'h05, 1'b0, 1, 1'b0, 1'b0};
        vecs[3]  = '{1, 8'h15, 1'b0, 0, 1'b0, 1'b0};
        vecs[4]  = '{0, 8'h05, 1'b0, 2, 1'b0, 1'b0};
        vecs[5]  = '{1, 8'h10, 1'b0, 1, 1'b0, 1'b0};
        vecs[6]  = '{1, 8'h10, 1'b1, 0, 1'b0, 1'b0};
        vecs[7]  = '{0, 8'h10, 1'b0, 0, 1'b0, 1'b1};
        vecs[8]  = '{0, 8'h2A, 1'b0, 2, 1'b1, 1'b0};
        vecs[9]  = '{0, 8'h2A, 1'b0, 0, 1'b0, 1'b0};
        vecs[10] = '{1, 8'h2A, 1'b0, 0, 1'b0, 1'b1};
        vecs[11] = '{0, 8'h23, 1'b0, 1, 1'b0, 1'b0};
        vecs[12] = '{1, 8'h23, 1'b0, 0, 1'b0, 1'b1};

        do_reset();
        check("rst_ready", 64'(bus.fetch_ready), 64'd0);
        check("rst_instr", 64'(bus.fetch_instruction), 64'd0);
        check("rst_mem_valid", 64'(bus.mem_read_valid), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_read_address), 64'd0);
        check_counters();

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].flush_before) do_flush();
            do_req(vecs[v].port, vecs[v].pc, vecs[v].exp_hit, vecs[v].delay, vecs[v].flush_in_fetch);
        end

        // Dropped requester must not be granted again.
        for (int i = 0; i < 4; i++) begin
            step();
            check("drop_no_regrant", 64'({bus.fetch_ready, bus.mem_read_valid}), 64'd0);
        end

        // Round-robin with both ports holding pre-filled pcs.
        do_reset();
        do_req(0, 8'h31, 1'b0, 0, 1'b0);
        do_req(1, 8'h42, 1'b0, 0, 1'b0);
        bus.fetch_pc    = {8'h42, 8'h31};
        bus.fetch_valid = 2'b11;
        for (int i = 1; i <= 14; i++) begin
            step();
            exp_rdy = '0;
            if (i <= 8 && (i % 2) == 0) exp_rdy = NP'(1 << ((i / 2 - 1) % 2));
            if (i == 11 || i == 14) exp_rdy = 2'b10;
            check("rr_ready", 64'(bus.fetch_ready), 64'(exp_rdy));
            if (exp_rdy == 2'b01) begin
                check("rr_data0", 64'(instr_of(0)), 64'(mem_data(8'h31)));
                m_hits++;
            end
            if (exp_rdy == 2'b10) begin
                check("rr_data1", 64'(instr_of(1)), 64'(mem_data(8'h42)));
                m_hits++;
            end
            if (i == 8) bus.fetch_valid[0] = 1'b0;
            if (i == 14) bus.fetch_valid[1] = 1'b0;
        end
        check("rr_no_mem", 64'(bus.mem_read_valid), 64'd0);
        check_counters();
        step();
        step();
        check("rr_quiet", 64'(bus.fetch_ready), 64'd0);

        // Reset while a miss is outstanding abandons it.
        bus.fetch_valid[0]   = 1'b1;
        bus.fetch_pc[0 +: AB] = 8'h77;
        step();
        bus.fetch_valid[0] = 1'b0;
        step();
        step();
        check("rst_fetch_pending", 64'(bus.mem_read_valid), 64'd1);
        reset              = 1'b1;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = mem_data(8'h77);
        step();
        reset              = 1'b0;
        bus.mem_read_ready = 1'b0;
        model_reset();
        check("rst_fetch_mem_valid", 64'(bus.mem_read_valid), 64'd0);
        check("rst_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        check_counters();
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_fetch_quiet", 64'({bus.fetch_ready, bus.mem_read_valid}), 64'd0);
        end
        do_req(1, 8'h77, model_hit(8'h77), 1, 1'b0);

        // Randomized single requests against the line-content model.
        for (int n = 0; n < 150; n++) begin
            rp  = $urandom_range(0, NP - 1);
            rpc = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 15) == 0) do_flush();
            do_req(rp, rpc, model_hit(rpc), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
